mips_front_pipe: RTL and testbench
==================================

# mips_front_pipe

Front half of the five-stage MIPS pipeline: instruction fetch, decode and execute, with the IF/ID and ID/EX pipeline registers inside the block. Branches and jumps resolve in decode. The register file lives here and is written back from the external MEM/WB stage. Hazard detection and forwarding-select generation sit outside the block; this block only applies the select inputs it receives.

## Interface
Parameters
- `IMEM_WORDS`, default 256: instruction-memory depth in 32-bit words, word-addressed by `PC[9:2]`.

Ports
- `Clk` — in, 1: rising-edge clock.
- `ResetN` — in, 1: asynchronous, active-low reset.
- `WriteData` — in, 32: instruction-memory load data.
- `WriteEnable` — in, 1: writes `WriteData` to the instruction memory at the current PC on the clock edge.
- `Stall` — in, 1: freeze request (behaviour under Operation).
- `WbRegWrite` — in, 1: register-file write enable from the write-back stage.
- `WbWriteReg` — in, 5: register-file write address.
- `WbWriteData` — in, 32: register-file write data.
- `ExMemAluResult` — in, 32: forwarding source, the EX/MEM ALU result.
- `MemReadData` — in, 32: forwarding source, the memory-stage read data.
- `ForwardA`, `ForwardB` — in, 2 each: ALU operand select. 0 = ID/EX register, 1 = `WbWriteData`, 2 = `ExMemAluResult`.
- `ForwardD`, `ForwardE` — in, 2 each: branch-compare rs/rt select. 0 = register file, 1 = `ExMemAluResult`, 2 = `MemReadData`.
- `ControlLines` — out, 12: decoded control for the instruction currently in IF/ID.
- `IdExControl` — out, 12: control lines held in ID/EX.
- `IfIdInstr` — out, 32: instruction held in IF/ID.
- `IdExRs`, `IdExRt`, `WriteReg` — out, 5 each: ID/EX rs, ID/EX rt, and the execute-stage destination register.
- `ReadData1`, `ReadData2` — out, 32: decode-stage register reads.
- `AluResult` — out, 32: execute-stage ALU result.
- `StoreData` — out, 32: forwarded B operand, used as store data.
- `Zero`, `Overflow` — out, 1 each: ALU flags.
- `PCSrc` — out, 1: redirect taken.
- `JumpReg` — out, 1: the instruction in decode is `jr`.

## Operation

Control-line bit map
- [11] RegWrite, [10] ALUSrc, [9] MemWrite, [8:5] ALUOp, [4] MemtoReg, [3] MemRead, [2] Branch, [1] Jump, [0] RegDst.

Instructions and ALU encoding
- ALUOp encoding: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 8 SLL, 9 SRL, 12 NOR.
- R-type (funct): add, sub, and, or, nor, slt, sll, srl, jr. SLL and SRL shift rt by `shamt`, taken from immediate bits [10:6].
- I-type: addi, andi, ori, lw, sw, beq, bne. Immediates are sign-extended, except andi/ori, which are zero-extended.
- J-type: j.
- Unknown opcodes decode to all-zero control lines (nop).

Fetch
- `PC` increments by 4 each cycle.
- When `PCSrc` is 1, `PC` loads the target instead of PC+4.
- The instruction-memory read is combinational at `PC`.

Decode
- Register file: 32×32. `$0` reads 0 and ignores writes.
- Same-cycle write/read of a nonzero register returns `WbWriteData` (write-through).
- Branch operands come through the `ForwardD`/`ForwardE` muxes.
- beq is taken when the operands are equal; bne when they are unequal.
- Branch target = IF/ID PC + 4 + (sign-extended immediate << 2).
- j target = {PC+4[31:28], instr[25:0], 2'b00}.
- jr target = forwarded rs.
- `PCSrc` = taken branch, j, or jr.

Execute
- Operand A = `ForwardA` mux output.
- Operand B = `ForwardB` mux output, or the immediate when ALUSrc = 1.
- `WriteReg` = rd when RegDst = 1, else rt.
- `Overflow` = signed overflow, for ADD/SUB only.
- `Zero` = (`AluResult` == 0).

Stall, flush and priority
- `Stall` = 1: PC and IF/ID hold, and ID/EX control loads 0 (a bubble).
- `PCSrc` = 1 with `Stall` = 0: IF/ID loads 0 (a nop) on the next edge, discarding the wrong-path fetch.
- `Stall` has priority over flush.

Write-enable collision
- A simultaneous `WriteEnable` and fetch at the same address returns the old word this cycle.

## Timing
- Reset (async, `ResetN` = 0) clears PC, IF/ID, ID/EX and all registers to 0. The instruction memory is not cleared.
- Outputs during reset: `AluResult` = 0, `Zero` = 1, `Overflow` = 0, `PCSrc` = 0, `ControlLines` = 0.
- An instruction fetched at edge n is in IF/ID after edge n and in ID/EX after edge n+1. `AluResult` is valid combinationally in that cycle.
- A taken branch/jump costs 1 cycle: the target instruction enters IF/ID two edges after the branch entered IF/ID.
- Register-file writes occur on the rising edge and are visible through the write-through path in the same cycle.
- A reset asserted mid-operation aborts in-flight instructions immediately. Fetch restarts at PC 0 on the first edge after release.

## Test plan
- Reset and sequential fetch: load 3 words at PC 0/4/8, release reset → `IfIdInstr` steps through the words on successive edges and PC = 12 after 3 edges.
- R-type ALU:
  - `add $3,$1,$2` with `WbWriteData`-loaded $1 = 5, $2 = 7 → `AluResult` = 12, `WriteReg` = 3, `IdExControl[11]` = 1.
  - `sub` of 0x80000000 − 1 → `Overflow` = 1.
- Shifts: `sll $2,$1,4` with $1 = 3 → `AluResult` = 48. slt with −1 vs 1 → 1.
- beq taken at PC 8, imm = 2 → `PCSrc` = 1, next fetch at 20, IF/ID = 0 for one cycle. The same case with unequal operands → not taken. With `ForwardD` = 1 and `ExMemAluResult` equal to rt → taken.
- Stall: hold `Stall` = 1 for 2 cycles → PC and `IfIdInstr` unchanged, `IdExControl` = 0. Stall plus taken branch → no flush until `Stall` drops.
- `$0` protection: WB write of 99 to `$0` → `ReadData1` for rs = 0 stays 0. Write-through: write 42 to $4 while decoding rs = 4 → `ReadData1` = 42 in the same cycle.

Source files
------------

// File: rtl/mips_front_pipe_if.sv
// Bus bundle for mips_front_pipe: imem load, write-back, forwarding selects and
// the decode/execute observation outputs.
interface mips_front_pipe_if;
  logic [31:0] WriteData;
  logic        WriteEnable;
  logic        Stall;
  logic        WbRegWrite;
  logic [4:0]  WbWriteReg;
  logic [31:0] WbWriteData;
  logic [31:0] ExMemAluResult;
  logic [31:0] MemReadData;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic [1:0]  ForwardD;
  logic [1:0]  ForwardE;
  logic [11:0] ControlLines;
  logic [11:0] IdExControl;
  logic [31:0] IfIdInstr;
  logic [4:0]  IdExRs;
  logic [4:0]  IdExRt;
  logic [4:0]  WriteReg;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] AluResult;
  logic [31:0] StoreData;
  logic        Zero;
  logic        Overflow;
  logic        PCSrc;
  logic        JumpReg;

  modport slave (
    input  WriteData, WriteEnable, Stall, WbRegWrite, WbWriteReg, WbWriteData,
           ExMemAluResult, MemReadData, ForwardA, ForwardB, ForwardD, ForwardE,
    output ControlLines, IdExControl, IfIdInstr, IdExRs, IdExRt, WriteReg,
           ReadData1, ReadData2, AluResult, StoreData, Zero, Overflow, PCSrc, JumpReg
  );

  modport master (
    output WriteData, WriteEnable, Stall, WbRegWrite, WbWriteReg, WbWriteData,
           ExMemAluResult, MemReadData, ForwardA, ForwardB, ForwardD, ForwardE,
    input  ControlLines, IdExControl, IfIdInstr, IdExRs, IdExRt, WriteReg,
           ReadData1, ReadData2, AluResult, StoreData, Zero, Overflow, PCSrc, JumpReg
  );
endinterface

// File: rtl/mips_front_pipe.sv
// MIPS fetch/decode/execute front end with IF/ID and ID/EX registers, register
// file and decode-stage branch resolution.
module mips_front_pipe #(
  parameter int IMEM_WORDS = 256
) (
  input  logic              Clk,
  input  logic              ResetN,
  mips_front_pipe_if.slave  bus
);
  localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  function automatic logic [11:0] pack_ctrl(input logic rw, input logic src, input logic mw,
                                            input logic [3:0] op, input logic m2r, input logic mr,
                                            input logic br, input logic jmp, input logic rdst);
    return {rw, src, mw, op, m2r, mr, br, jmp, rdst};
  endfunction

  logic [31:0] imem_q [IMEM_WORDS];
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] pc_q, pc_d, ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d;
  logic [11:0] idex_ctrl_q, idex_ctrl_d;
  logic [4:0]  idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d, idex_rd_q, idex_rd_d;
  logic [4:0]  idex_shamt_q, idex_shamt_d;
  logic [31:0] idex_rd1_q, idex_rd1_d, idex_rd2_q, idex_rd2_d, idex_imm_q, idex_imm_d;

  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rs_s, rt_s;
  logic [11:0] ctrl_s;
  logic [31:0] imm_ext_s, rd1_s, rd2_s, br_rs_s, br_rt_s, target_s, fetch_s, pc4_s;
  logic        jump_reg_s, taken_s, pcsrc_s;
  logic [31:0] a_s, bfwd_s, b_s, alu_s;
  logic        ovf_s;

  assign opcode_s = ifid_instr_q[31:26];
  assign funct_s  = ifid_instr_q[5:0];
  assign rs_s     = ifid_instr_q[25:21];
  assign rt_s     = ifid_instr_q[20:16];
  assign pc4_s    = pc_q + 32'd4;
  assign fetch_s  = imem_q[pc_q[AW+1:2]];

  // Main decoder; the all-zero word is the canonical nop.
  always_comb begin
    ctrl_s     = 12'd0;
    jump_reg_s = 1'b0;
    imm_ext_s  = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
    if (ifid_instr_q == 32'd0) begin
      ctrl_s = 12'd0;
    end else begin
      case (opcode_s)
        6'h00: begin
          case (funct_s)
            6'h20:   ctrl_s = pack_ctrl(1'b1, 1'b0, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            6'h22:   ctrl_s = pack_ctrl(1'b1, 1'b0, 1'b0, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            6'h24:   ctrl_s = pack_ctrl(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            6'h25:   ctrl_s = pack_ctrl(1'b1, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            6'h27:   ctrl_s = pack_ctrl(1'b1, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            6'h2A:   ctrl_s = pack_ctrl(1'b1, 1'b0, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            6'h00:   ctrl_s = pack_ctrl(1'b1, 1'b0, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            6'h02:   ctrl_s = pack_ctrl(1'b1, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            6'h08:   jump_reg_s = 1'b1;
            default: ctrl_s = 12'd0;
          endcase
        end
        6'h08: ctrl_s = pack_ctrl(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        6'h0C: begin
          ctrl_s    = pack_ctrl(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          imm_ext_s = {16'd0, ifid_instr_q[15:0]};
        end
        6'h0D: begin
          ctrl_s    = pack_ctrl(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          imm_ext_s = {16'd0, ifid_instr_q[15:0]};
        end
        6'h23:   ctrl_s = pack_ctrl(1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        6'h2B:   ctrl_s = pack_ctrl(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        6'h04:   ctrl_s = pack_ctrl(1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        6'h05:   ctrl_s = pack_ctrl(1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        6'h02:   ctrl_s = pack_ctrl(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        default: ctrl_s = 12'd0;
      endcase
    end
  end

  // Register-file reads with write-through of the concurrent write-back.
  always_comb begin
    rd1_s = regs_q[rs_s];
    rd2_s = regs_q[rt_s];
    if (rs_s == 5'd0) rd1_s = 32'd0;
    else if (bus.WbRegWrite && (bus.WbWriteReg == rs_s)) rd1_s = bus.WbWriteData;
    else rd1_s = regs_q[rs_s];
    if (rt_s == 5'd0) rd2_s = 32'd0;
    else if (bus.WbRegWrite && (bus.WbWriteReg == rt_s)) rd2_s = bus.WbWriteData;
    else rd2_s = regs_q[rt_s];
  end

  // Branch/jump resolution in decode.
  always_comb begin
    case (bus.ForwardD)
      2'd1:    br_rs_s = bus.ExMemAluResult;
      2'd2:    br_rs_s = bus.MemReadData;
      default: br_rs_s = rd1_s;
    endcase
    case (bus.ForwardE)
      2'd1:    br_rt_s = bus.ExMemAluResult;
      2'd2:    br_rt_s = bus.MemReadData;
      default: br_rt_s = rd2_s;
    endcase
    taken_s = ctrl_s[2] && ((opcode_s == 6'h04) ? (br_rs_s == br_rt_s) : (br_rs_s != br_rt_s));
    pcsrc_s = taken_s || ctrl_s[1] || jump_reg_s;
    if (jump_reg_s) target_s = br_rs_s;
    else if (ctrl_s[1]) target_s = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};
    else target_s = ifid_pc4_q + {imm_ext_s[29:0], 2'b00};
  end

  // Next-state for PC and pipeline registers; stall outranks flush.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    if (bus.Stall) begin
      pc_d = pc_q;
    end else if (pcsrc_s) begin
      pc_d         = target_s;
      ifid_instr_d = 32'd0;
      ifid_pc4_d   = 32'd0;
    end else begin
      pc_d         = pc4_s;
      ifid_instr_d = fetch_s;
      ifid_pc4_d   = pc4_s;
    end
    idex_ctrl_d  = bus.Stall ? 12'd0 : ctrl_s;
    idex_rs_d    = rs_s;
    idex_rt_d    = rt_s;
    idex_rd_d    = ifid_instr_q[15:11];
    idex_shamt_d = ifid_instr_q[10:6];
    idex_rd1_d   = rd1_s;
    idex_rd2_d   = rd2_s;
    idex_imm_d   = imm_ext_s;
    regs_d       = regs_q;
    if (bus.WbRegWrite && (bus.WbWriteReg != 5'd0)) regs_d[bus.WbWriteReg] = bus.WbWriteData;
    else regs_d = regs_q;
  end

  // Pipeline state and register file.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      pc_q         <= 32'd0;
      ifid_instr_q <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      idex_ctrl_q  <= 12'd0;
      idex_rs_q    <= 5'd0;
      idex_rt_q    <= 5'd0;
      idex_rd_q    <= 5'd0;
      idex_shamt_q <= 5'd0;
      idex_rd1_q   <= 32'd0;
      idex_rd2_q   <= 32'd0;
      idex_imm_q   <= 32'd0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      idex_shamt_q <= idex_shamt_d;
      idex_rd1_q   <= idex_rd1_d;
      idex_rd2_q   <= idex_rd2_d;
      idex_imm_q   <= idex_imm_d;
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Instruction memory survives reset; the read above still sees the old word.
  always_ff @(posedge Clk) begin
    if (bus.WriteEnable) imem_q[pc_q[AW+1:2]] <= bus.WriteData;
  end

  // Execute: operand forwarding and ALU.
  always_comb begin
    case (bus.ForwardA)
      2'd1:    a_s = bus.WbWriteData;
      2'd2:    a_s = bus.ExMemAluResult;
      default: a_s = idex_rd1_q;
    endcase
    case (bus.ForwardB)
      2'd1:    bfwd_s = bus.WbWriteData;
      2'd2:    bfwd_s = bus.ExMemAluResult;
      default: bfwd_s = idex_rd2_q;
    endcase
    b_s   = idex_ctrl_q[10] ? idex_imm_q : bfwd_s;
    ovf_s = 1'b0;
    case (idex_ctrl_q[8:5])
      4'd0:  alu_s = a_s & b_s;
      4'd1:  alu_s = a_s | b_s;
      4'd2: begin
        alu_s = a_s + b_s;
        ovf_s = (a_s[31] == b_s[31]) && (alu_s[31] != a_s[31]);
      end
      4'd6: begin
        alu_s = a_s - b_s;
        ovf_s = (a_s[31] != b_s[31]) && (alu_s[31] != a_s[31]);
      end
      4'd7:    alu_s = ($signed(a_s) < $signed(b_s)) ? 32'd1 : 32'd0;
      4'd8:    alu_s = bfwd_s << idex_shamt_q;
      4'd9:    alu_s = bfwd_s >> idex_shamt_q;
      4'd12:   alu_s = ~(a_s | b_s);
      default: alu_s = 32'd0;
    endcase
  end

  assign bus.ControlLines = ctrl_s;
  assign bus.IdExControl  = idex_ctrl_q;
  assign bus.IfIdInstr    = ifid_instr_q;
  assign bus.IdExRs       = idex_rs_q;
  assign bus.IdExRt       = idex_rt_q;
  assign bus.WriteReg     = idex_ctrl_q[0] ? idex_rd_q : idex_rt_q;
  assign bus.ReadData1    = rd1_s;
  assign bus.ReadData2    = rd2_s;
  assign bus.AluResult    = alu_s;
  assign bus.StoreData    = bfwd_s;
  assign bus.Zero         = (alu_s == 32'd0);
  assign bus.Overflow     = ovf_s;
  assign bus.PCSrc        = pcsrc_s;
  assign bus.JumpReg      = jump_reg_s;
endmodule

// File: tb/tb_mips_front_pipe.sv
// Directed bench for mips_front_pipe: loads a small program, then walks it
// edge by edge with hand-computed expectations.
module tb_mips_front_pipe;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  logic [31:0] prog [30];
  localparam logic [31:0] FILL = 32'h2014_0001;

  mips_front_pipe_if bus_if ();
  mips_front_pipe #(.IMEM_WORDS(256)) dut (.Clk(clk), .ResetN(rst_n), .bus(bus_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd,
                                         input int sh, input int fn);
    r_type = {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt,
                                         input logic [15:0] imm);
    i_type = {op[5:0], rs[4:0], rt[4:0], imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    bus_if.WbRegWrite  = we;
    bus_if.WbWriteReg  = r;
    bus_if.WbWriteData = d;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int k = 0; k < 30; k++) prog[k] = 32'd0;
    prog[0]  = r_type(1, 2, 3, 0, 32);
    prog[1]  = r_type(6, 7, 5, 0, 34);
    prog[2]  = r_type(0, 8, 9, 4, 0);
    prog[3]  = r_type(11, 12, 10, 0, 42);
    prog[4]  = i_type(4, 1, 2, 16'd2);
    prog[5]  = i_type(4, 1, 2, 16'd2);
    prog[6]  = FILL;
    prog[7]  = FILL;
    prog[8]  = i_type(4, 0, 0, 16'd3);
    prog[9]  = FILL;
    prog[12] = r_type(4, 0, 15, 0, 32);
    prog[13] = r_type(0, 0, 16, 0, 32);
    prog[14] = {6'h02, 26'd20};
    prog[15] = FILL;
    prog[20] = r_type(17, 0, 0, 0, 8);
    prog[21] = FILL;
    prog[25] = i_type(13, 0, 18, 16'h8001);
    prog[26] = i_type(8, 0, 19, 16'hFFFF);
    prog[27] = i_type(5, 1, 2, 16'd1);
    prog[28] = FILL;
    prog[29] = r_type(0, 8, 21, 1, 2);

    rst_n = 1'b0;
    bus_if.WriteData = 32'd0;  bus_if.WriteEnable = 1'b0;  bus_if.Stall = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    bus_if.ExMemAluResult = 32'd0;  bus_if.MemReadData = 32'd0;
    bus_if.ForwardA = 2'd0;  bus_if.ForwardB = 2'd0;
    bus_if.ForwardD = 2'd0;  bus_if.ForwardE = 2'd0;
    tick; tick;
    chk("rst_ifid", bus_if.IfIdInstr, 32'd0);
    chk("rst_ctrl", {20'd0, bus_if.ControlLines}, 32'd0);
    chk("rst_alu", bus_if.AluResult, 32'd0);
    chk("rst_zero", {31'd0, bus_if.Zero}, 32'd1);
    chk("rst_ovf", {31'd0, bus_if.Overflow}, 32'd0);
    chk("rst_pcsrc", {31'd0, bus_if.PCSrc}, 32'd0);

    // Load the program: each edge writes at the current PC, which advances by 4.
    rst_n = 1'b1;
    bus_if.WriteEnable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      bus_if.WriteData = prog[k];
      tick;
    end
    bus_if.WriteEnable = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    wb(1'b1, 5'd1, 32'd5);
    tick;                                            // edge 1
    chk("fetch0", bus_if.IfIdInstr, prog[0]);
    wb(1'b1, 5'd2, 32'd7);
    #1;
    chk("add_rd1", bus_if.ReadData1, 32'd5);
    chk("add_rd2_wt", bus_if.ReadData2, 32'd7);
    chk("add_ctrl", {20'd0, bus_if.ControlLines}, 32'h841);
    tick;                                            // edge 2
    chk("fetch1", bus_if.IfIdInstr, prog[1]);
    wb(1'b1, 5'd8, 32'd3);
    #1;
    chk("add_res", bus_if.AluResult, 32'd12);
    chk("add_wreg", {27'd0, bus_if.WriteReg}, 32'd3);
    chk("add_idex_rw", {31'd0, bus_if.IdExControl[11]}, 32'd1);
    tick;                                            // edge 3
    chk("fetch2", bus_if.IfIdInstr, prog[2]);
    wb(1'b1, 5'd12, 32'd1);
    bus_if.ForwardA = 2'd2;  bus_if.ExMemAluResult = 32'h8000_0000;  bus_if.ForwardB = 2'd1;
    #1;
    chk("sub_res", bus_if.AluResult, 32'h7FFF_FFFF);
    chk("sub_ovf", {31'd0, bus_if.Overflow}, 32'd1);
    tick;                                            // edge 4
    bus_if.ForwardA = 2'd0;  bus_if.ForwardB = 2'd0;  bus_if.ExMemAluResult = 32'd0;
    wb(1'b1, 5'd11, 32'hFFFF_FFFF);
    #1;
    chk("sll_res", bus_if.AluResult, 32'd48);
    chk("sll_wreg", {27'd0, bus_if.WriteReg}, 32'd9);
    tick;                                            // edge 5
    wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("slt_res", bus_if.AluResult, 32'd1);
    chk("beq_ne_pcsrc", {31'd0, bus_if.PCSrc}, 32'd0);
    tick;                                            // edge 6
    bus_if.ForwardD = 2'd1;  bus_if.ExMemAluResult = 32'd7;
    #1;
    chk("beq_fwd_pcsrc", {31'd0, bus_if.PCSrc}, 32'd1);
    tick;                                            // edge 7
    bus_if.ForwardD = 2'd0;  bus_if.ExMemAluResult = 32'd0;
    chk("beq_flush", bus_if.IfIdInstr, 32'd0);
    tick;                                            // edge 8
    chk("beq_target", bus_if.IfIdInstr, prog[8]);
    chk("beq_eq_pcsrc", {31'd0, bus_if.PCSrc}, 32'd1);
    bus_if.Stall = 1'b1;
    tick;                                            // edge 9
    chk("stall1_ifid", bus_if.IfIdInstr, prog[8]);
    chk("stall1_bubble", {20'd0, bus_if.IdExControl}, 32'd0);
    chk("stall1_pcsrc", {31'd0, bus_if.PCSrc}, 32'd1);
    tick;                                            // edge 10
    chk("stall2_ifid", bus_if.IfIdInstr, prog[8]);
    chk("stall2_bubble", {20'd0, bus_if.IdExControl}, 32'd0);
    bus_if.Stall = 1'b0;
    tick;                                            // edge 11
    chk("unstall_flush", bus_if.IfIdInstr, 32'd0);
    chk("beq_idex_ctrl", {20'd0, bus_if.IdExControl}, 32'h0C4);
    wb(1'b1, 5'd0, 32'd99);
    tick;                                            // edge 12
    chk("stall_target", bus_if.IfIdInstr, prog[12]);
    wb(1'b1, 5'd4, 32'd42);
    #1;
    chk("wt_rd1", bus_if.ReadData1, 32'd42);
    chk("r0_rd2", bus_if.ReadData2, 32'd0);
    tick;                                            // edge 13
    wb(1'b1, 5'd0, 32'd99);
    #1;
    chk("r0_wt_rd1", bus_if.ReadData1, 32'd0);
    chk("wt_add_res", bus_if.AluResult, 32'd42);
    tick;                                            // edge 14
    wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("j_pcsrc", {31'd0, bus_if.PCSrc}, 32'd1);
    tick;                                            // edge 15
    chk("j_flush", bus_if.IfIdInstr, 32'd0);
    tick;                                            // edge 16
    chk("j_target", bus_if.IfIdInstr, prog[20]);
    wb(1'b1, 5'd17, 32'd100);
    #1;
    chk("jr_flag", {31'd0, bus_if.JumpReg}, 32'd1);
    chk("jr_pcsrc", {31'd0, bus_if.PCSrc}, 32'd1);
    tick;                                            // edge 17
    wb(1'b0, 5'd0, 32'd0);
    chk("jr_flush", bus_if.IfIdInstr, 32'd0);
    tick;                                            // edge 18
    chk("jr_target", bus_if.IfIdInstr, prog[25]);
    tick;                                            // edge 19
    chk("ori_res", bus_if.AluResult, 32'h0000_8001);
    chk("ori_ctrl", {20'd0, bus_if.IdExControl}, 32'hC20);
    tick;                                            // edge 20
    chk("addi_res", bus_if.AluResult, 32'hFFFF_FFFF);
    chk("bne_pcsrc", {31'd0, bus_if.PCSrc}, 32'd1);
    tick;                                            // edge 21
    chk("bne_flush", bus_if.IfIdInstr, 32'd0);
    tick;                                            // edge 22
    chk("bne_target", bus_if.IfIdInstr, prog[29]);
    tick;                                            // edge 23
    chk("srl_res", bus_if.AluResult, 32'd1);
    chk("srl_wreg", {27'd0, bus_if.WriteReg}, 32'd21);

    // Mid-run reset aborts the pipeline immediately.
    rst_n = 1'b0;
    #1;
    chk("abort_idex", {20'd0, bus_if.IdExControl}, 32'd0);
    chk("abort_alu", bus_if.AluResult, 32'd0);
    chk("abort_zero", {31'd0, bus_if.Zero}, 32'd1);
    tick;
    // Write and fetch at PC 0 in the same cycle: the old word is fetched.
    rst_n = 1'b1;
    bus_if.WriteEnable = 1'b1;
    bus_if.WriteData   = 32'hFFFF_FFFF;
    tick;
    bus_if.WriteEnable = 1'b0;
    chk("collide_old", bus_if.IfIdInstr, prog[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
